cache_flush_ctrl: RTL and testbench

Sequencer that walks every set/way of a set-associative cache to write back dirty lines and clear their dirty bits on a flush request. It also issues a whole-cache invalidate that clears all valid bits and the replacement state. Sits between the hazard/CSR logic (fence, cache-management ops) and the cache arrays and bus-side writeback interface. It is the sole driver of flush addressing while active.

---
 rtl/cache_flush_ctrl.sv | 171 +++++++++++++++++
 tb/tb_cache_flush_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_flush_ctrl.sv
// cache_flush_ctrl: walks every set/way of a set-associative cache, writes back
// valid+dirty lines and clears their dirty bits. Also issues a whole-cache
// invalidate, either on its own or after a flush walk.
// Optional feature macro: CACHE_FLUSH_WBCOUNT_EN adds the WBCount output, which
// counts the writebacks completed by the most recent flush.
//
// Timing: a clean or invalid way costs one cycle. The step to the next way is
// taken in the same cycle as a clean CHECK decision, or in the WB cycle that
// sees WBAck. Each new set adds one READ cycle, so a flush with no dirty lines
// takes NUMLINES*(NUMWAYS+1)+1 cycles. That count includes the DONE cycle.
module cache_flush_ctrl #(
  parameter int NUMWAYS  = 4,
  parameter int NUMLINES = 128,
  parameter int SETLEN   = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               FlushReq,
  input  logic               InvalReq,
  input  logic [NUMWAYS-1:0] DirtyWay,
  input  logic [NUMWAYS-1:0] ValidWay,
  input  logic               WBAck,
  output logic               SelFlush,
  output logic [SETLEN-1:0]  FlushSet,
  output logic [NUMWAYS-1:0] FlushWay,
  output logic               WBReq,
  output logic               ClearDirty,
  output logic               InvalidateCache,
  output logic               Busy,
  output logic               FlushDone
`ifdef CACHE_FLUSH_WBCOUNT_EN
  ,
  output logic [SETLEN+$clog2(NUMWAYS):0] WBCount
`endif
);

  localparam int WAYLEN = $clog2(NUMWAYS);

  // The per-way step is folded into CHECK and WB, so no separate state exists for it.
  typedef enum logic [2:0] {
    IDLE,
    READ,
    CHECK,
    WB,
    INVAL,
    DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [SETLEN-1:0] set_reg, set_next;
  logic [WAYLEN-1:0] way_reg, way_next;
  logic              pend_reg, pend_next;
  logic              step;
  logic              last_way;
  logic              last_set;

  assign last_way = (way_reg == WAYLEN'(NUMWAYS - 1));
  assign last_set = (set_reg == SETLEN'(NUMLINES - 1));

  // State, walk counters and the sticky pending-invalidate flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      set_reg   <= '0;
      way_reg   <= '0;
      pend_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      set_reg   <= set_next;
      way_reg   <= way_next;
      pend_reg  <= pend_next;
    end
  end

  // Next-state, counter stepping and Moore/Mealy outputs.
  always_comb begin
    state_next      = state_reg;
    set_next        = set_reg;
    way_next        = way_reg;
    pend_next       = pend_reg;
    step            = 1'b0;
    SelFlush        = 1'b0;
    WBReq           = 1'b0;
    ClearDirty      = 1'b0;
    InvalidateCache = 1'b0;
    FlushDone       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (FlushReq) begin
          state_next = READ;
          // An invalidate requested together with a flush runs after the walk.
          if (InvalReq) pend_next = 1'b1;
        end else if (InvalReq) begin
          state_next = INVAL;
        end
      end
      READ: begin
        SelFlush   = 1'b1;
        state_next = CHECK;
        if (InvalReq) pend_next = 1'b1;
      end
      CHECK: begin
        SelFlush = 1'b1;
        if (InvalReq) pend_next = 1'b1;
        if (ValidWay[way_reg] && DirtyWay[way_reg]) state_next = WB;
        else step = 1'b1;
      end
      WB: begin
        SelFlush = 1'b1;
        WBReq    = 1'b1;
        if (InvalReq) pend_next = 1'b1;
        if (WBAck) begin
          ClearDirty = 1'b1;
          step       = 1'b1;
        end
      end
      INVAL: begin
        InvalidateCache = 1'b1;
        pend_next       = 1'b0;
        // The flag is set only by a flush, so it tells where INVAL was entered from.
        state_next      = pend_reg ? DONE : IDLE;
      end
      DONE: begin
        FlushDone  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Advance to the next way. The counters are powers of two, so they wrap on their own.
    if (step) begin
      way_next = way_reg + 1'b1;
      if (last_way) begin
        set_next = set_reg + 1'b1;
        if (last_set) state_next = pend_next ? INVAL : DONE;
        else state_next = READ;
      end else begin
        state_next = CHECK;
      end
    end
  end

  assign Busy     = (state_reg != IDLE);
  assign FlushSet = set_reg;

  // One-hot decode of the way counter.
  generate
    for (genvar gi = 0; gi < NUMWAYS; gi++) begin : g_way_dec
      assign FlushWay[gi] = (way_reg == WAYLEN'(gi));
    end
  endgenerate

`ifdef CACHE_FLUSH_WBCOUNT_EN
  logic [SETLEN+WAYLEN:0] wbcount_reg;

  // Count writebacks of the current flush. The count is held after FlushDone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wbcount_reg <= '0;
    end else if (state_reg == IDLE && state_next == READ) begin
      wbcount_reg <= '0;
    end else if (ClearDirty) begin
      wbcount_reg <= wbcount_reg + 1'b1;
    end
  end

  assign WBCount = wbcount_reg;
`endif

endmodule

// File: tb/tb_cache_flush_ctrl.sv
// tb_cache_flush_ctrl: directed bench for cache_flush_ctrl with a small cache
// array model, a writeback responder and a writeback scoreboard.
// Optional feature macro: CACHE_FLUSH_WBCOUNT_EN enables the WBCount checks.
module tb_cache_flush_ctrl;
  localparam int NW = 4;
  localparam int NL = 128;
  localparam int SL = 7;

  logic          clk;
  logic          reset;
  logic          FlushReq;
  logic          InvalReq;
  logic [NW-1:0] DirtyWay;
  logic [NW-1:0] ValidWay;
  logic          WBAck;
  logic          SelFlush;
  logic [SL-1:0] FlushSet;
  logic [NW-1:0] FlushWay;
  logic          WBReq;
  logic          ClearDirty;
  logic          InvalidateCache;
  logic          Busy;
  logic          FlushDone;
`ifdef CACHE_FLUSH_WBCOUNT_EN
  logic [SL+2:0] WBCount;
`endif

  int tests = 0;
  int fails = 0;

  logic [NW-1:0] dirty_mem[NL];
  logic [NW-1:0] valid_mem[NL];

  typedef struct packed {
    logic [SL-1:0] set;
    logic [NW-1:0] way;
  } wb_t;
  wb_t wb_q[$];

  int ack_delay;
  int ack_cnt;

  cache_flush_ctrl #(.NUMWAYS(NW), .NUMLINES(NL), .SETLEN(SL)) dut (
    .clk(clk),
    .reset(reset),
    .FlushReq(FlushReq),
    .InvalReq(InvalReq),
    .DirtyWay(DirtyWay),
    .ValidWay(ValidWay),
    .WBAck(WBAck),
    .SelFlush(SelFlush),
    .FlushSet(FlushSet),
    .FlushWay(FlushWay),
    .WBReq(WBReq),
    .ClearDirty(ClearDirty),
    .InvalidateCache(InvalidateCache),
    .Busy(Busy),
    .FlushDone(FlushDone)
`ifdef CACHE_FLUSH_WBCOUNT_EN
    ,
    .WBCount(WBCount)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cache arrays: the dirty and valid bits of FlushSet appear one cycle later.
  always @(posedge clk) begin
    DirtyWay <= dirty_mem[FlushSet];
    ValidWay <= valid_mem[FlushSet];
  end

  // Bus responder: acks in the ack_delay-th WBReq cycle. A delay of 0 never acks.
  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      ack_cnt = 0;
      WBAck   = 1'b0;
    end else if (WBReq) begin
      ack_cnt = ack_cnt + 1;
      WBAck   = (ack_delay != 0) && (ack_cnt == ack_delay);
    end else begin
      ack_cnt = 0;
      WBAck   = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mark_dirty(input int set, input int way, input logic valid);
    wb_t e;
    dirty_mem[set][way] = 1'b1;
    valid_mem[set][way] = valid;
    if (valid) begin
      e.set = SL'(set);
      e.way = NW'(1 << way);
      wb_q.push_back(e);
    end
  endtask

  // Run one flush and check latency, writeback traffic and invalidate placement.
  task automatic run_flush(input string name, input int exp_lat, input int exp_wbreq,
                           input int exp_clear, input int exp_inval,
                           input logic inval_with, input int inval_at);
    int  done_cyc;
    int  wbreq_cyc;
    int  clear_cnt;
    int  inval_cnt;
    int  inval_cyc;
    int  busy_low;
    bit  pulsed;
    wb_t e;
    done_cyc  = 0;
    wbreq_cyc = 0;
    clear_cnt = 0;
    inval_cnt = 0;
    inval_cyc = 0;
    busy_low  = 0;
    pulsed    = 1'b0;
    @(negedge clk);
    FlushReq = 1'b1;
    InvalReq = inval_with;
    @(posedge clk);
    #1;
    FlushReq = 1'b0;
    InvalReq = 1'b0;
    for (int c = 1; c <= 3000 && done_cyc == 0; c++) begin
      @(negedge clk);
      #1;
      InvalReq = 1'b0;
      if (c == 1) begin
        check({name, ":start_set"}, 32'(FlushSet), 32'd0);
        check({name, ":start_way"}, 32'(FlushWay), 32'd1);
      end
      if (!Busy) busy_low++;
      if (WBReq) begin
        wbreq_cyc++;
        if (wb_q.size() > 0) check({name, ":wb_addr"}, 32'({FlushSet, FlushWay}), 32'(wb_q[0]));
      end
      if (ClearDirty) begin
        clear_cnt++;
        if (wb_q.size() == 0) begin
          check({name, ":sb_nonempty"}, 32'(wb_q.size()), 32'd1);
        end else begin
          e = wb_q.pop_front();
          check({name, ":clear_addr"}, 32'({FlushSet, FlushWay}), 32'(e));
          dirty_mem[FlushSet] = dirty_mem[FlushSet] & ~FlushWay;
        end
      end
      if (InvalidateCache) begin
        inval_cnt++;
        inval_cyc = c;
      end
      if (inval_at >= 0 && !pulsed && int'(FlushSet) == inval_at) begin
        InvalReq = 1'b1;
        pulsed   = 1'b1;
      end
      if (FlushDone) done_cyc = c;
    end
    check({name, ":latency"}, 32'(done_cyc), 32'(exp_lat));
    check({name, ":wbreq_cycles"}, 32'(wbreq_cyc), 32'(exp_wbreq));
    check({name, ":clear_count"}, 32'(clear_cnt), 32'(exp_clear));
    check({name, ":inval_count"}, 32'(inval_cnt), 32'(exp_inval));
    check({name, ":busy_low"}, 32'(busy_low), 32'd0);
    if (exp_inval > 0) check({name, ":inval_before_done"}, 32'(inval_cyc), 32'(done_cyc - 1));
    $display("[TB] %s: latency=%0d wbreq=%0d clear=%0d inval=%0d", name, done_cyc, wbreq_cyc,
             clear_cnt, inval_cnt);
  endtask

  initial begin
    int  seen;
    int  late_done;
    int  late_busy;
    reset     = 1'b0;
    FlushReq  = 1'b0;
    InvalReq  = 1'b0;
    ack_delay = 3;
    for (int s = 0; s < NL; s++) begin
      dirty_mem[s] = '0;
      valid_mem[s] = '1;
    end

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst:SelFlush", 32'(SelFlush), 32'd0);
    check("rst:FlushSet", 32'(FlushSet), 32'd0);
    check("rst:FlushWay", 32'(FlushWay), 32'd1);
    check("rst:WBReq", 32'(WBReq), 32'd0);
    check("rst:ClearDirty", 32'(ClearDirty), 32'd0);
    check("rst:Inval", 32'(InvalidateCache), 32'd0);
    check("rst:Busy", 32'(Busy), 32'd0);
    check("rst:FlushDone", 32'(FlushDone), 32'd0);
    $display("[TB] reset state checked");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Clean cache
    run_flush("clean", 641, 0, 0, 0, 1'b0, -1);

    // One dirty line, set 5 way 2
    mark_dirty(5, 2, 1'b1);
    run_flush("dirty_s5w2", 644, 3, 1, 0, 1'b0, -1);

    // Dirty but invalid line, set 0 way 0
    mark_dirty(0, 0, 1'b0);
    run_flush("dirty_invalid", 641, 0, 0, 0, 1'b0, -1);
    dirty_mem[0] = '0;
    valid_mem[0] = '1;

    // Flush and invalidate requested together
    run_flush("flush_inval", 642, 0, 0, 1, 1'b1, -1);

    // Invalidate requested mid-walk at set 60
    run_flush("inval_mid", 642, 0, 0, 1, 1'b0, 60);

    // Invalidate alone from IDLE
    @(negedge clk);
    InvalReq = 1'b1;
    @(posedge clk);
    #1;
    InvalReq = 1'b0;
    check("inval_only:pulse", 32'(InvalidateCache), 32'd1);
    check("inval_only:busy", 32'(Busy), 32'd1);
    check("inval_only:nodone", 32'(FlushDone), 32'd0);
    @(posedge clk);
    #1;
    check("inval_only:pulse_end", 32'(InvalidateCache), 32'd0);
    check("inval_only:busy_end", 32'(Busy), 32'd0);
    late_done = 0;
    late_busy = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      if (FlushDone) late_done++;
      if (Busy) late_busy++;
    end
    check("inval_only:no_flushdone", 32'(late_done), 32'd0);
    check("inval_only:idle", 32'(late_busy), 32'd0);
    $display("[TB] inval_only checked");

    // Three writebacks, including the very last set/way
    mark_dirty(1, 0, 1'b1);
    mark_dirty(64, 3, 1'b1);
    mark_dirty(127, 3, 1'b1);
    run_flush("three_wb", 650, 9, 3, 0, 1'b0, -1);
`ifdef CACHE_FLUSH_WBCOUNT_EN
    check("wbcount:after_done", 32'(WBCount), 32'd3);
    repeat (3) @(negedge clk);
    #1;
    check("wbcount:held", 32'(WBCount), 32'd3);
`endif

    // Reset during a writeback at set 10
    mark_dirty(10, 1, 1'b1);
    ack_delay = 0;
    @(negedge clk);
    FlushReq = 1'b1;
    @(posedge clk);
    #1;
    FlushReq = 1'b0;
    seen = 0;
    for (int c = 0; c < 2000 && seen == 0; c++) begin
      @(negedge clk);
      #1;
      if (WBReq) seen = 1;
    end
    check("rst_wb:wbreq_seen", 32'(seen), 32'd1);
    check("rst_wb:set", 32'(FlushSet), 32'd10);
    #1;
    reset = 1'b0;
    #1;
    check("rst_wb:WBReq", 32'(WBReq), 32'd0);
    check("rst_wb:ClearDirty", 32'(ClearDirty), 32'd0);
    check("rst_wb:Busy", 32'(Busy), 32'd0);
    check("rst_wb:SelFlush", 32'(SelFlush), 32'd0);
    check("rst_wb:FlushSet", 32'(FlushSet), 32'd0);
    check("rst_wb:FlushWay", 32'(FlushWay), 32'd1);
    check("rst_wb:Inval", 32'(InvalidateCache), 32'd0);
    check("rst_wb:FlushDone", 32'(FlushDone), 32'd0);
`ifdef CACHE_FLUSH_WBCOUNT_EN
    check("rst_wb:WBCount", 32'(WBCount), 32'd0);
`endif
    $display("[TB] reset during WB checked");
    @(negedge clk);
    @(negedge clk);
    reset     = 1'b1;
    ack_delay = 3;
    run_flush("after_reset", 644, 3, 1, 0, 1'b0, -1);

    check("sb:drained", 32'(wb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
